// File: rtl/i2s_rx_if.sv
// Frame-side bundle of the I2S receiver: one stereo sample pair plus its handshake.
// Valid/ready: a frame transfers on a clock where data_valid and data_ready are both 1;
// the master holds data_valid high until that transfer, although new serial frames may
// replace audio_l/audio_r while it waits, and data_ready is ignored while data_valid is 0.
interface i2s_rx_if #(
    parameter int DATA_BIT = 16
);
    logic [DATA_BIT-1:0] audio_l;
    logic [DATA_BIT-1:0] audio_r;
    logic                data_valid;
    logic                data_ready;

    modport master (
        output audio_l,
        output audio_r,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  audio_l,
        input  audio_r,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S master receiver: derives SCLK/LRCLK from an 8-bit MCLK counter and deserializes stereo frames.
// Optional sticky overrun detection is built only when I2S_RX_OVERRUN_EN is defined.
module i2s_rx #(
    parameter int DATA_BIT = 16
) (
    input  logic     i_clk_12_288,
    input  logic     i_reset_n,
    input  logic     i_rx_sd,
    output logic     o_rx_mclk,
    output logic     o_rx_sclk,
    output logic     o_rx_lrclk,
    output logic     o_overrun,
    i2s_rx_if.master rx_if
);
    localparam logic [4:0] LAST_SLOT = 5'(DATA_BIT);

    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_BIT-1:0] shift_l_q, shift_l_d;
    logic [DATA_BIT-1:0] shift_r_q, shift_r_d;
    logic [DATA_BIT-1:0] audio_l_q, audio_l_d;
    logic [DATA_BIT-1:0] audio_r_q, audio_r_d;
    logic                valid_q, valid_d;
    logic [4:0]          slot;
    logic                strobe;
    logic                data_slot;
    logic                frame_done;

    always_comb begin
        cnt_d      = cnt_q + 8'd1;
        slot       = cnt_q[6:2];
        strobe     = (cnt_q[1:0] == 2'b10);
        // Slot 0 is the one-bit I2S delay; slots past the word width carry nothing.
        data_slot  = strobe && (slot != 5'd0) && (slot <= LAST_SLOT);
        frame_done = data_slot && cnt_q[7] && (slot == LAST_SLOT);

        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        if (data_slot) begin
            if (cnt_q[7]) begin
                shift_r_d = {shift_r_q[DATA_BIT-2:0], i_rx_sd};
            end else begin
                shift_l_d = {shift_l_q[DATA_BIT-2:0], i_rx_sd};
            end
        end

        audio_l_d = audio_l_q;
        audio_r_d = audio_r_q;
        valid_d   = valid_q;
        if (valid_q && rx_if.data_ready) begin
            valid_d = 1'b0;
        end
        // The last right bit arrives on the completing strobe, so take it from shift_r_d.
        if (frame_done) begin
            audio_l_d = shift_l_q;
            audio_r_d = shift_r_d;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge i_clk_12_288) begin
        if (!i_reset_n) begin
            cnt_q     <= '0;
            shift_l_q <= '0;
            shift_r_q <= '0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            shift_l_q <= shift_l_d;
            shift_r_q <= shift_r_d;
            audio_l_q <= audio_l_d;
            audio_r_q <= audio_r_d;
            valid_q   <= valid_d;
        end
    end

`ifdef I2S_RX_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky: a frame replaced before the consumer took it; only reset clears it.
    always_comb begin
        overrun_d = overrun_q | (frame_done & valid_q & ~rx_if.data_ready);
    end

    always_ff @(posedge i_clk_12_288) begin
        if (!i_reset_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign o_overrun = overrun_q;
`else
    assign o_overrun = 1'b0;
`endif

    assign o_rx_mclk        = i_clk_12_288;
    assign o_rx_sclk        = cnt_q[1];
    assign o_rx_lrclk       = cnt_q[7];
    assign rx_if.audio_l    = audio_l_q;
    assign rx_if.audio_r    = audio_r_q;
    assign rx_if.data_valid = valid_q;
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: a 16-bit and a 24-bit receiver share clock and reset,
// each fed by an ADC model that follows the bench's own copy of the MCLK counter.
module tb_i2s_rx;
`ifdef I2S_RX_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic sd, sd24;
    logic mclk, sclk, lrclk, ovr;
    logic mclk24, sclk24, lrclk24, ovr24;
    logic [7:0]  tb_cnt;
    logic [15:0] tx_l, tx_r, nxt_l, nxt_r;
    logic [23:0] tx24_l, tx24_r, nxt24_l, nxt24_r;
    int checks;
    int errors;

    i2s_rx_if #(.DATA_BIT(16)) bus16 ();
    i2s_rx_if #(.DATA_BIT(24)) bus24 ();

    i2s_rx #(.DATA_BIT(16)) u_dut (
        .i_clk_12_288 (clk),
        .i_reset_n    (rst_n),
        .i_rx_sd      (sd),
        .o_rx_mclk    (mclk),
        .o_rx_sclk    (sclk),
        .o_rx_lrclk   (lrclk),
        .o_overrun    (ovr),
        .rx_if        (bus16)
    );

    i2s_rx #(.DATA_BIT(24)) u_dut24 (
        .i_clk_12_288 (clk),
        .i_reset_n    (rst_n),
        .i_rx_sd      (sd24),
        .o_rx_mclk    (mclk24),
        .o_rx_sclk    (sclk24),
        .o_rx_lrclk   (lrclk24),
        .o_overrun    (ovr24),
        .rx_if        (bus24)
    );

    // Clock / reset-synchronous reference counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!rst_n) tb_cnt <= 8'd0;
        else        tb_cnt <= tb_cnt + 8'd1;
    end

    // ADC models: data changes while SCLK is low; unused slots carry junk
    always @(negedge clk) begin : adc_drv
        int b;
        if (tb_cnt == 8'd0) begin
            tx_l   = nxt_l;
            tx_r   = nxt_r;
            tx24_l = nxt24_l;
            tx24_r = nxt24_r;
        end
        b = int'(tb_cnt[6:2]);
        if (b >= 1 && b <= 16) sd = tb_cnt[7] ? tx_r[16-b] : tx_l[16-b];
        else                   sd = 1'($urandom_range(0, 1));
        if (b >= 1 && b <= 24) sd24 = tb_cnt[7] ? tx24_r[24-b] : tx24_l[24-b];
        else                   sd24 = tb_cnt[2];
    end

    task automatic wait_cnt(input logic [7:0] c);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tb_cnt == c) return;
        end
        errors++;
        $display("FAIL wait_cnt: counter value %0d never seen, required %0d", tb_cnt, c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus16.audio_l !== 16'h0) begin errors++; $display("FAIL rst_audio_l: got %h want 0000", bus16.audio_l); end
        checks++; if (bus16.audio_r !== 16'h0) begin errors++; $display("FAIL rst_audio_r: got %h want 0000", bus16.audio_r); end
        checks++; if (bus16.data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus16.data_valid); end
        checks++; if (sclk !== 1'b0 || lrclk !== 1'b0) begin errors++; $display("FAIL rst_clks: sclk=%b lrclk=%b want 0/0", sclk, lrclk); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", ovr); end
        checks++; if (bus24.audio_l !== 24'h0 || bus24.data_valid !== 1'b0) begin errors++; $display("FAIL rst_dut24: l=%h v=%b want 0/0", bus24.audio_l, bus24.data_valid); end
        checks++; if (mclk !== 1'b0) begin errors++; $display("FAIL mclk_low: got %b want 0", mclk); end
        @(posedge clk); #1;
        checks++; if (mclk !== 1'b1) begin errors++; $display("FAIL mclk_high: got %b want 1", mclk); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_frame();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bus16.data_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL first_valid: no valid within 300 clocks, required at cnt 195");
        end else begin
            checks++; if (tb_cnt !== 8'd195) begin errors++; $display("FAIL first_latency: valid at cnt %0d want 195", tb_cnt); end
            checks++; if (bus16.audio_l !== 16'hA5C3) begin errors++; $display("FAIL first_l: got %h want a5c3", bus16.audio_l); end
            checks++; if (bus16.audio_r !== 16'h1234) begin errors++; $display("FAIL first_r: got %h want 1234", bus16.audio_r); end
            @(negedge clk);
            checks++; if (bus16.data_valid !== 1'b0) begin errors++; $display("FAIL first_accept: valid %b want 0", bus16.data_valid); end
        end
    endtask

    task automatic test_free_run();
        logic [15:0] pl [4];
        logic [15:0] pr [4];
        int pulses, last_v, s_rises, s_bad, last_s, lr_rises, lr_bad, last_lr;
        logic prev_s, prev_lr;
        pl = '{16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF};
        pr = '{16'h4000, 16'h0FF0, 16'hFFFE, 16'h8001};
        pulses = 0; last_v = -1; s_rises = 0; s_bad = 0; last_s = -1;
        lr_rises = 0; lr_bad = 0; last_lr = -1;
        wait_cnt(8'd200);
        nxt_l = pl[0]; nxt_r = pr[0];
        prev_s = sclk; prev_lr = lrclk;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (sclk && !prev_s) begin
                if (last_s >= 0 && i - last_s != 4) s_bad++;
                last_s = i; s_rises++;
            end
            if (lrclk && !prev_lr) begin
                if (last_lr >= 0 && i - last_lr != 256) lr_bad++;
                last_lr = i; lr_rises++;
            end
            prev_s = sclk; prev_lr = lrclk;
            if (bus16.data_valid === 1'b1) begin
                pulses++;
                if (pulses <= 4) begin
                    checks++; if (bus16.audio_l !== pl[pulses-1] || bus16.audio_r !== pr[pulses-1]) begin
                        errors++; $display("FAIL run_frame%0d: got %h/%h want %h/%h", pulses, bus16.audio_l, bus16.audio_r, pl[pulses-1], pr[pulses-1]);
                    end
                    if (pulses < 4) begin nxt_l = pl[pulses]; nxt_r = pr[pulses]; end
                end
                if (last_v >= 0) begin
                    checks++; if (i - last_v != 256) begin errors++; $display("FAIL run_spacing: gap %0d want 256", i - last_v); end
                end
                last_v = i;
            end
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL run_pulses: got %0d want 4", pulses); end
        checks++; if (s_rises != 256 || s_bad != 0) begin errors++; $display("FAIL sclk_period: rises %0d bad %0d want 256/0", s_rises, s_bad); end
        checks++; if (lr_rises != 4 || lr_bad != 0) begin errors++; $display("FAIL lrclk_period: rises %0d bad %0d want 4/0", lr_rises, lr_bad); end
    endtask

    task automatic test_hold();
        int lows;
        bus16.data_ready = 1'b0;
        nxt_l = 16'h1111; nxt_r = 16'h3333;
        wait_cnt(8'd195);
        checks++; if (bus16.data_valid !== 1'b1 || bus16.audio_l !== 16'h1111) begin errors++; $display("FAIL hold_f1: v=%b l=%h want 1/1111", bus16.data_valid, bus16.audio_l); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL hold_ovr_f1: got %b want 0", ovr); end
        nxt_l = 16'h2222; nxt_r = 16'h4444;
        lows = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (bus16.data_valid !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL hold_valid: low for %0d clocks want 0", lows); end
        checks++; if (bus16.audio_l !== 16'h2222 || bus16.audio_r !== 16'h4444) begin errors++; $display("FAIL hold_f2: got %h/%h want 2222/4444", bus16.audio_l, bus16.audio_r); end
        checks++; if (ovr !== OVR_EXP) begin errors++; $display("FAIL hold_overrun: got %b want %b", ovr, OVR_EXP); end
        bus16.data_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus16.data_valid !== 1'b0 || bus16.audio_l !== 16'h2222) begin errors++; $display("FAIL hold_accept: v=%b l=%h want 0/2222", bus16.data_valid, bus16.audio_l); end
        checks++; if (ovr !== OVR_EXP) begin errors++; $display("FAIL overrun_sticky: got %b want %b", ovr, OVR_EXP); end
    endtask

    task automatic test_back_to_back();
        wait_cnt(8'd200);
        bus16.data_ready = 1'b0;
        nxt_l = 16'h5555; nxt_r = 16'h6666;
        wait_cnt(8'd195);
        nxt_l = 16'h7777; nxt_r = 16'h8888;
        wait_cnt(8'd194);
        checks++; if (bus16.data_valid !== 1'b1 || bus16.audio_l !== 16'h5555 || bus16.audio_r !== 16'h6666) begin
            errors++; $display("FAIL b2b_pending: v=%b %h/%h want 1 5555/6666", bus16.data_valid, bus16.audio_l, bus16.audio_r);
        end
        bus16.data_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus16.data_valid !== 1'b1 || bus16.audio_l !== 16'h7777 || bus16.audio_r !== 16'h8888) begin
            errors++; $display("FAIL b2b_new: v=%b %h/%h want 1 7777/8888", bus16.data_valid, bus16.audio_l, bus16.audio_r);
        end
        @(negedge clk);
        checks++; if (bus16.data_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept: valid %b want 0", bus16.data_valid); end
    endtask

    task automatic test_mid_reset();
        logic found;
        wait_cnt(8'd200);
        nxt_l = 16'hFFFF; nxt_r = 16'hFFFF;
        wait_cnt(8'd60);
        rst_n = 1'b0;
        nxt_l = 16'h0F0F; nxt_r = 16'hF0F0;
        repeat (3) @(negedge clk);
        checks++; if (bus16.audio_l !== 16'h0 || bus16.audio_r !== 16'h0 || bus16.data_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_out: %h/%h v=%b want 0000/0000 0", bus16.audio_l, bus16.audio_r, bus16.data_valid);
        end
        checks++; if (sclk !== 1'b0 || lrclk !== 1'b0 || ovr !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ctl: sclk=%b lrclk=%b ovr=%b want 0/0/0", sclk, lrclk, ovr);
        end
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bus16.data_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mid_rst_valid: no valid within 300 clocks, required at cnt 195");
        end else begin
            checks++; if (tb_cnt !== 8'd195 || bus16.audio_l !== 16'h0F0F || bus16.audio_r !== 16'hF0F0) begin
                errors++; $display("FAIL mid_rst_frame: cnt %0d %h/%h want 195 0f0f/f0f0", tb_cnt, bus16.audio_l, bus16.audio_r);
            end
        end
    endtask

    task automatic test_width24();
        logic found;
        for (int f = 0; f < 2; f++) begin
            found = 1'b0;
            for (int i = 0; i < 300 && !found; i++) begin
                @(negedge clk);
                if (bus24.data_valid === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++; $display("FAIL w24_valid%0d: no valid within 300 clocks, required at cnt 227", f);
            end else begin
                checks++; if (tb_cnt !== 8'd227) begin errors++; $display("FAIL w24_latency%0d: cnt %0d want 227", f, tb_cnt); end
                checks++;
                if (f == 0 && (bus24.audio_l !== 24'h800001 || bus24.audio_r !== 24'h7FFFFE)) begin
                    errors++; $display("FAIL w24_frame0: got %h/%h want 800001/7ffffe", bus24.audio_l, bus24.audio_r);
                end else if (f == 1 && (bus24.audio_l !== 24'h123456 || bus24.audio_r !== 24'hFEDCBA)) begin
                    errors++; $display("FAIL w24_frame1: got %h/%h want 123456/fedcba", bus24.audio_l, bus24.audio_r);
                end
                nxt24_l = 24'h123456; nxt24_r = 24'hFEDCBA;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; sd = 1'b0; sd24 = 1'b0;
        bus16.data_ready = 1'b1;
        bus24.data_ready = 1'b1;
        nxt_l = 16'hA5C3; nxt_r = 16'h1234;
        tx_l = 16'hA5C3;  tx_r = 16'h1234;
        nxt24_l = 24'h800001; nxt24_r = 24'h7FFFFE;
        tx24_l = 24'h800001;  tx24_r = 24'h7FFFFE;
        test_reset();
        test_first_frame();
        test_free_run();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        test_width24();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
